mux_pkt_arbiter: RTL and testbench



---
 rtl/mux_pkt_arbiter_pkg.sv | 24 ++
 rtl/mux_pkt_arbiter_credit_counter.sv | 47 ++++
 rtl/mux_pkt_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mux_pkt_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkt_arbiter_pkg.sv
// Shared encodings for the router output mux and its packet arbiter.
//   TYPE_*      : 2-bit flit type carried in the top bits of each flit
//   arb_state_e : arbiter FSM states
//   PORT_P1     : width of the one-hot mux select bus
//   VCHW        : width of the flit type field
package mux_pkt_arbiter_pkg;

  localparam int unsigned PORT_P1 = 5;
  localparam int unsigned VCHW    = 2;

  typedef enum logic [VCHW-1:0] {
    TYPE_NONE = 2'b00,
    TYPE_HEAD = 2'b01,
    TYPE_DATA = 2'b10,
    TYPE_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mux_pkt_arbiter_credit_counter.sv
// Saturating up/down credit counter for the downstream buffer.
//   clk, rst_  : clock, asynchronous active-low reset (loads CREDITS)
//   inc        : one credit returned this cycle
//   dec        : one flit consumed a credit this cycle
//   cnt        : current credit count
//   has_credit : cnt is non-zero
module credit_counter #(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CNTW    = 3
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            has_credit
);

  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(CREDITS);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            dec_ok;

  assign has_credit = (cnt_q != '0);
  // A decrement at zero is ignored so the count never wraps.
  assign dec_ok     = dec && has_credit;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc, dec_ok})
      2'b10:   cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= MAX_CNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mux_pkt_arbiter.sv
// Packet-level round-robin arbiter driving the 2:1 router output mux select.
// A HEAD flit is granted in the same cycle it arrives; the grant is then
// held until that input's TAIL fires. All transfers need a downstream credit.
//   clk, rst_          : clock, asynchronous active-low reset
//   ivalid_n, itype_n  : valid and flit type of mux input n (n = 0, 1)
//   credit_in          : one credit returned by downstream
//   sel                : one-hot mux select (bit0 = input 0, bit1 = input 1)
//   ordy_0, ordy_1     : input n may transfer this cycle
//   ofire              : a flit crosses the mux this cycle
//   credit_cnt         : current credit count
//   err                : sticky protocol error
// Optional build macro MUX_ARB_CHECK_EN enables the protocol checks on err;
// without it err is tied low.
module mux_pkt_arbiter
  import mux_pkt_arbiter_pkg::*;
#(
  parameter int unsigned PORTW   = 5,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CNTW    = 3
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ivalid_0,
  input  logic [1:0]       itype_0,
  input  logic             ivalid_1,
  input  logic [1:0]       itype_1,
  input  logic             credit_in,
  output logic [PORTW-1:0] sel,
  output logic             ordy_0,
  output logic             ordy_1,
  output logic             ofire,
  output logic [CNTW-1:0]  credit_cnt,
  output logic             err
);

  arb_state_e state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       has_credit;
  logic       req_0, req_1;
  logic       sel_0, sel_1;
  logic       rdy_0, rdy_1;
  logic       fire;

  assign req_0 = ivalid_0 && (itype_0 == TYPE_HEAD);
  assign req_1 = ivalid_1 && (itype_1 == TYPE_HEAD);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_0    = 1'b0;
    sel_1    = 1'b0;
    rdy_0    = 1'b0;
    rdy_1    = 1'b0;
    fire     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (has_credit && (req_0 || req_1)) begin
          // rr_ptr holds the last winner; the other input is preferred.
          if (req_0 && (!req_1 || rr_ptr_q)) begin
            sel_0   = 1'b1;
            rdy_0   = 1'b1;
            fire    = 1'b1;
            state_d = LOCK0;
          end else begin
            sel_1   = 1'b1;
            rdy_1   = 1'b1;
            fire    = 1'b1;
            state_d = LOCK1;
          end
        end
      end
      LOCK0: begin
        sel_0 = 1'b1;
        rdy_0 = has_credit;
        fire  = ivalid_0 && has_credit;
        if (fire && (itype_0 == TYPE_TAIL)) begin
          state_d  = IDLE;
          rr_ptr_d = 1'b0;
        end
      end
      LOCK1: begin
        sel_1 = 1'b1;
        rdy_1 = has_credit;
        fire  = ivalid_1 && has_credit;
        if (fire && (itype_1 == TYPE_TAIL)) begin
          state_d  = IDLE;
          rr_ptr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    sel    = '0;
    sel[0] = sel_0;
    sel[1] = sel_1;
  end

  assign ordy_0 = rdy_0;
  assign ordy_1 = rdy_1;
  assign ofire  = fire;

  credit_counter #(
    .CREDITS(CREDITS),
    .CNTW   (CNTW)
  ) u_credit (
    .clk       (clk),
    .rst_      (rst_),
    .inc       (credit_in),
    .dec       (fire),
    .cnt       (credit_cnt),
    .has_credit(has_credit)
  );

`ifdef MUX_ARB_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (credit_in && (credit_cnt == CNTW'(CREDITS))) begin
      err_d = 1'b1;
    end
    if ((state_q == IDLE) &&
        ((ivalid_0 && ((itype_0 == TYPE_DATA) || (itype_0 == TYPE_TAIL))) ||
         (ivalid_1 && ((itype_1 == TYPE_DATA) || (itype_1 == TYPE_TAIL))))) begin
      err_d = 1'b1;
    end
    if (fire && (((state_q == LOCK0) && (itype_0 == TYPE_HEAD)) ||
                 ((state_q == LOCK1) && (itype_1 == TYPE_HEAD)))) begin
      err_d = 1'b1;
    end
    if ((ivalid_0 && (itype_0 == TYPE_NONE)) ||
        (ivalid_1 && (itype_1 == TYPE_NONE))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pkt_arbiter.sv
module tb_mux_pkt_arbiter;

  localparam logic [1:0] N = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] D = 2'b10;
  localparam logic [1:0] T = 2'b11;

`ifdef MUX_ARB_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       ivalid_0 = 1'b0;
  logic [1:0] itype_0 = 2'b00;
  logic       ivalid_1 = 1'b0;
  logic [1:0] itype_1 = 2'b00;
  logic       credit_in = 1'b0;
  logic [4:0] sel;
  logic       ordy_0, ordy_1, ofire, err;
  logic [2:0] credit_cnt;

  int total = 0;
  int bad   = 0;

  mux_pkt_arbiter #(
    .PORTW  (5),
    .CREDITS(4),
    .CNTW   (3)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .ivalid_0  (ivalid_0),
    .itype_0   (itype_0),
    .ivalid_1  (ivalid_1),
    .itype_1   (itype_1),
    .credit_in (credit_in),
    .sel       (sel),
    .ordy_0    (ordy_0),
    .ordy_1    (ordy_1),
    .ofire     (ofire),
    .credit_cnt(credit_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [1:0] t0;
    logic       v1;
    logic [1:0] t1;
    logic       cr;
    logic [4:0] sel;
    logic       r0;
    logic       r1;
    logic       f;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [1:0] t0,
                       input logic v1, input logic [1:0] t1, input logic cr);
    ivalid_0  = v0;
    itype_0   = t0;
    ivalid_1  = v1;
    itype_1   = t1;
    credit_in = cr;
  endtask

  // Called at posedge+1: moves to the sampling point (negedge).
  task automatic to_sample();
    #4;
  endtask

  // Called at negedge: moves to posedge+1.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    drive(1'b0, N, 1'b0, N, 1'b0);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  initial begin
    int nf;

    //                 v0 t0  v1 t1  cr   sel      r0 r1 f  cnt
    tbl[0]  = '{1'b0, N, 1'b0, N, 1'b0, 5'b00000, 0, 0, 0, 3'd4};
    tbl[1]  = '{1'b1, D, 1'b0, N, 1'b0, 5'b00000, 0, 0, 0, 3'd4};
    tbl[2]  = '{1'b1, H, 1'b1, H, 1'b0, 5'b00001, 1, 0, 1, 3'd4};
    tbl[3]  = '{1'b1, D, 1'b1, H, 1'b0, 5'b00001, 1, 0, 1, 3'd3};
    tbl[4]  = '{1'b0, N, 1'b1, H, 1'b1, 5'b00001, 1, 0, 0, 3'd2};
    tbl[5]  = '{1'b1, T, 1'b1, H, 1'b1, 5'b00001, 1, 0, 1, 3'd3};
    tbl[6]  = '{1'b1, H, 1'b1, H, 1'b0, 5'b00010, 0, 1, 1, 3'd3};
    tbl[7]  = '{1'b1, H, 1'b1, T, 1'b1, 5'b00010, 0, 1, 1, 3'd2};
    tbl[8]  = '{1'b1, H, 1'b1, H, 1'b0, 5'b00001, 1, 0, 1, 3'd2};
    tbl[9]  = '{1'b1, D, 1'b0, N, 1'b0, 5'b00001, 1, 0, 1, 3'd1};
    tbl[10] = '{1'b1, D, 1'b0, N, 1'b0, 5'b00001, 0, 0, 0, 3'd0};
    tbl[11] = '{1'b1, D, 1'b0, N, 1'b1, 5'b00001, 0, 0, 0, 3'd0};
    tbl[12] = '{1'b1, T, 1'b0, N, 1'b0, 5'b00001, 1, 0, 1, 3'd1};
    tbl[13] = '{1'b0, N, 1'b1, H, 1'b1, 5'b00000, 0, 0, 0, 3'd0};
    tbl[14] = '{1'b0, N, 1'b1, H, 1'b0, 5'b00010, 0, 1, 1, 3'd1};
    tbl[15] = '{1'b0, N, 1'b1, T, 1'b1, 5'b00010, 0, 0, 0, 3'd0};
    tbl[16] = '{1'b0, N, 1'b1, T, 1'b0, 5'b00010, 0, 1, 1, 3'd1};
    tbl[17] = '{1'b0, N, 1'b0, N, 1'b1, 5'b00000, 0, 0, 0, 3'd0};
    tbl[18] = '{1'b0, N, 1'b0, N, 1'b1, 5'b00000, 0, 0, 0, 3'd1};
    tbl[19] = '{1'b0, N, 1'b0, N, 1'b1, 5'b00000, 0, 0, 0, 3'd2};
    tbl[20] = '{1'b0, N, 1'b0, N, 1'b1, 5'b00000, 0, 0, 0, 3'd3};
    tbl[21] = '{1'b0, N, 1'b0, N, 1'b1, 5'b00000, 0, 0, 0, 3'd4};
    tbl[22] = '{1'b0, N, 1'b0, N, 1'b0, 5'b00000, 0, 0, 0, 3'd4};

    #1;
    do_reset();

    // Reset state
    to_sample();
    chk("rst_sel", int'(sel), 0);
    chk("rst_ordy0", int'(ordy_0), 0);
    chk("rst_ordy1", int'(ordy_1), 0);
    chk("rst_ofire", int'(ofire), 0);
    chk("rst_cnt", int'(credit_cnt), 4);
    chk("rst_err", int'(err), 0);
    next_cycle();

    // Table-driven cycle sequence
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].v0, tbl[i].t0, tbl[i].v1, tbl[i].t1, tbl[i].cr);
      to_sample();
      chk($sformatf("v%0d_sel", i), int'(sel), int'(tbl[i].sel));
      chk($sformatf("v%0d_ordy0", i), int'(ordy_0), int'(tbl[i].r0));
      chk($sformatf("v%0d_ordy1", i), int'(ordy_1), int'(tbl[i].r1));
      chk($sformatf("v%0d_ofire", i), int'(ofire), int'(tbl[i].f));
      chk($sformatf("v%0d_cnt", i), int'(credit_cnt), int'(tbl[i].cnt));
      next_cycle();
    end

    // Long packet on input 1, credit returned one cycle after each fire
    do_reset();
    nf = 0;
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, N, 1'b1, (i == 0) ? H : ((i == 21) ? T : D), (i != 0));
      to_sample();
      chk($sformatf("long%0d_sel", i), int'(sel), 2);
      chk($sformatf("long%0d_ordy0", i), int'(ordy_0), 0);
      if (ofire) nf++;
      next_cycle();
    end
    chk("long_fires", nf, 22);
    drive(1'b0, N, 1'b0, N, 1'b1);
    to_sample();
    chk("long_idle_sel", int'(sel), 0);
    chk("long_cnt3", int'(credit_cnt), 3);
    next_cycle();
    drive(1'b1, H, 1'b1, H, 1'b0);
    to_sample();
    chk("long_rr_sel", int'(sel), 1);
    chk("long_cnt4", int'(credit_cnt), 4);
    next_cycle();

    // Credit exhaustion with no returns
    do_reset();
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) ? H : D, 1'b0, N, 1'b0);
      to_sample();
      if (ofire) nf++;
      next_cycle();
    end
    chk("stall_fires", nf, 4);
    drive(1'b1, D, 1'b0, N, 1'b0);
    to_sample();
    chk("stall_cnt", int'(credit_cnt), 0);
    chk("stall_sel", int'(sel), 1);
    chk("stall_ordy0", int'(ordy_0), 0);
    next_cycle();
    nf = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, D, 1'b0, N, (i == 0));
      to_sample();
      if (ofire) nf++;
      next_cycle();
    end
    chk("stall_one_more", nf, 1);
    chk("stall_cnt_end", int'(credit_cnt), 0);

    // Asynchronous reset mid-packet
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 0) ? H : D, 1'b0, N, (i != 0));
      to_sample();
      next_cycle();
    end
    rst_ = 1'b0;
    #1;
    chk("arst_sel", int'(sel), 0);
    chk("arst_ordy0", int'(ordy_0), 0);
    chk("arst_ofire", int'(ofire), 0);
    chk("arst_cnt", int'(credit_cnt), 4);
    drive(1'b0, N, 1'b1, H, 1'b0);
    rst_ = 1'b1;
    #1;
    chk("arst_new_sel", int'(sel), 2);
    chk("arst_new_ordy1", int'(ordy_1), 1);
    chk("arst_new_ofire", int'(ofire), 1);
    #2;
    next_cycle();

    // Protocol error flag
    do_reset();
    to_sample();
    chk("err_clr_a", int'(err), 0);
    next_cycle();
    drive(1'b1, D, 1'b0, N, 1'b0);
    to_sample();
    chk("err_data_idle_ofire", int'(ofire), 0);
    next_cycle();
    drive(1'b0, N, 1'b0, N, 1'b0);
    to_sample();
    chk("err_data_idle", int'(err), ERR_EXP);
    next_cycle();
    next_cycle();
    to_sample();
    chk("err_sticky", int'(err), ERR_EXP);
    next_cycle();
    do_reset();
    to_sample();
    chk("err_clr_b", int'(err), 0);
    next_cycle();
    drive(1'b0, N, 1'b0, N, 1'b1);
    to_sample();
    next_cycle();
    drive(1'b0, N, 1'b0, N, 1'b0);
    to_sample();
    chk("err_credit_full", int'(err), ERR_EXP);
    chk("err_credit_sat", int'(credit_cnt), 4);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
